ad7928_emu: RTL and testbench



---
 rtl/ad7928_emu_pkg.sv | 31 +++
 rtl/ad7928_emu_if.sv | 21 ++
 rtl/ad7928_emu_edge.sv | 43 ++++
 rtl/ad7928_emu.sv | 122 ++++++++++++
 tb/tb_ad7928_emu.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/ad7928_emu_pkg.sv
// rtl/ad7928_emu_pkg.sv - AD7928 emulator constants, control-word bit map and FSM states
package ad7928_pkg;

  localparam int AD7928_FRAME_BITS = 16;
  localparam int AD7928_CTRL_BITS  = 12;

  localparam int AD7928_CTRL_WRITE   = 11;
  localparam int AD7928_CTRL_SEQ     = 10;
  localparam int AD7928_CTRL_ADD_MSB = 8;
  localparam int AD7928_CTRL_ADD_LSB = 6;
  localparam int AD7928_CTRL_PM_MSB  = 5;
  localparam int AD7928_CTRL_PM_LSB  = 4;
  localparam int AD7928_CTRL_SHADOW  = 3;
  localparam int AD7928_CTRL_RANGE   = 1;
  localparam int AD7928_CTRL_CODING  = 0;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  // Outgoing frame: leading zero, channel address, sample. CODING=0 selects
  // offset-binary, which is the two's-complement value with the MSB flipped.
  function automatic logic [15:0] ad7928_miso_word(input logic [2:0]  ch,
                                                   input logic [11:0] value,
                                                   input logic        coding);
    return {1'b0, ch, value[11] ^ ~coding, value[10:0]};
  endfunction

endpackage

// File: rtl/ad7928_emu_if.sv
// rtl/ad7928_emu_if.sv - SPI bus between the ADC-reading master and the AD7928 emulator
interface ad7928_emu_if;
  logic spi_ss;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_ss,
    output spi_sck,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_ss,
    input  spi_sck,
    input  spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/ad7928_emu_edge.sv
// rtl/ad7928_emu_edge.sv - input conditioner: optional 2-FF sync (AD7928_EMU_SYNC_EN) plus edge detect
module ad7928_emu_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall,
  output logic rise
);

  logic prev;

`ifdef AD7928_EMU_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {2{RST_VAL}};
    end else begin
      sync <= {sync[0], raw};
    end
  end

  assign level = sync[1];
`else
  // Same-clock master: the pin is already synchronous to clk.
  assign level = raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= RST_VAL;
    end else begin
      prev <= level;
    end
  end

  assign fall = prev & ~level;
  assign rise = ~prev & level;

endmodule

// File: rtl/ad7928_emu.sv
// rtl/ad7928_emu.sv - AD7928 SPI ADC responder; AD7928_EMU_SYNC_EN adds input synchronizers
module ad7928_emu
  import ad7928_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  ad7928_emu_if.slave       spi,
  input  logic [11:0]       i_ch_value [8],
  output logic              o_frame,
  output logic [11:0]       o_ctrl,
  output logic [2:0]        o_ch,
  output logic              o_abort
);

  localparam logic [4:0] FCNT_DONE = 5'(AD7928_FRAME_BITS);
  localparam logic [4:0] FCNT_CAP  = 5'(AD7928_CTRL_BITS);

  logic ss_level, ss_fall, ss_rise;
  logic sck_level, sck_fall, sck_rise;
  logic mosi_level, mosi_fall, mosi_rise;

  ad7928_emu_edge #(.RST_VAL(1'b1)) u_ss_edge (
    .clk   (clk),
    .rst   (rst),
    .raw   (spi.spi_ss),
    .level (ss_level),
    .fall  (ss_fall),
    .rise  (ss_rise)
  );

  ad7928_emu_edge #(.RST_VAL(1'b1)) u_sck_edge (
    .clk   (clk),
    .rst   (rst),
    .raw   (spi.spi_sck),
    .level (sck_level),
    .fall  (sck_fall),
    .rise  (sck_rise)
  );

  ad7928_emu_edge #(.RST_VAL(1'b0)) u_mosi_edge (
    .clk   (clk),
    .rst   (rst),
    .raw   (spi.spi_mosi),
    .level (mosi_level),
    .fall  (mosi_fall),
    .rise  (mosi_rise)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, sck_level, sck_rise, mosi_fall, mosi_rise};

  state_t      state;
  logic [15:0] shreg;
  logic [11:0] cap;
  logic [4:0]  fcnt;
  logic        miso;

  assign spi.spi_miso = miso;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WAIT_IDLE;
      shreg   <= '0;
      cap     <= '0;
      fcnt    <= '0;
      miso    <= 1'b1;
      o_frame <= 1'b0;
      o_abort <= 1'b0;
      o_ctrl  <= '0;
      o_ch    <= '0;
    end else begin
      o_frame <= 1'b0;
      o_abort <= 1'b0;
      unique case (state)
        // A bus still low after reset belongs to a frame we never saw start.
        WAIT_IDLE: begin
          miso <= 1'b1;
          if (ss_level) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          miso <= 1'b1;
          if (ss_fall) begin
            state <= SHIFT;
            shreg <= ad7928_miso_word(o_ch, i_ch_value[o_ch], o_ctrl[AD7928_CTRL_CODING]);
            cap   <= '0;
            fcnt  <= '0;
            miso  <= 1'b0;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state <= IDLE;
            miso  <= 1'b1;
            if (fcnt >= FCNT_DONE) begin
              o_frame <= 1'b1;
              if (cap[AD7928_CTRL_WRITE]) begin
                o_ctrl <= cap;
                o_ch   <= cap[AD7928_CTRL_ADD_MSB:AD7928_CTRL_ADD_LSB];
              end
            end else begin
              o_abort <= 1'b1;
            end
          end else if (sck_fall && fcnt < FCNT_DONE) begin
            fcnt  <= fcnt + 5'd1;
            miso  <= shreg[14];
            shreg <= {shreg[14:0], 1'b0};
            if (fcnt < FCNT_CAP) begin
              cap <= {cap[10:0], mosi_level};
            end
          end
        end
        default: begin
          state <= WAIT_IDLE;
          miso  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad7928_emu.sv
// tb/tb_ad7928_emu.sv - self-checking bench for ad7928_emu against a frame-level model
module tb_ad7928_emu;

`ifdef AD7928_EMU_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int HALF = 4;

  logic        clk;
  logic        rst;
  logic [11:0] ch_value [8];
  logic        o_frame;
  logic [11:0] o_ctrl;
  logic [2:0]  o_ch;
  logic        o_abort;

  ad7928_emu_if spi_bus();

  ad7928_emu dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (spi_bus),
    .i_ch_value (ch_value),
    .o_frame    (o_frame),
    .o_ctrl     (o_ctrl),
    .o_ch       (o_ch),
    .o_abort    (o_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state and per-cycle expectations
  logic [11:0] mdl_ctrl = 12'h000;
  logic [2:0]  mdl_ch   = 3'd0;
  logic        exp_miso = 1'b1;
  logic        exp_frame = 1'b0;
  logic        exp_abort = 1'b0;
  logic        miso_chk = 1'b0;
  logic        chk_on = 1'b0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("o_frame", 16'(o_frame), 16'(exp_frame));
      chk("o_abort", 16'(o_abort), 16'(exp_abort));
      chk("o_ctrl", 16'(o_ctrl), 16'(mdl_ctrl));
      chk("o_ch", 16'(o_ch), 16'(mdl_ch));
      if (miso_chk) chk("spi_miso", 16'(spi_bus.spi_miso), 16'(exp_miso));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word the master must clock in: address on top, sample offset by half scale when CODING=0
  function automatic logic [15:0] model_word();
    logic [11:0] v;
    v = ch_value[mdl_ch];
    if (mdl_ctrl[0] == 1'b0) v = v + 12'h800;
    return 16'(mdl_ch) * 16'd4096 + 16'(v);
  endfunction

  task automatic frame(input logic [11:0] cw, input int nfalls, input int rst_at,
                       output logic [15:0] word);
    logic [15:0] expw;
    logic        dead;
    expw = model_word();
    word = '0;
    dead = 1'b0;
    repeat (4) tick();
    spi_bus.spi_ss = 1'b0;
    miso_chk = 1'b0;
    repeat (LAT) tick();
    exp_miso = 1'b0;
    miso_chk = 1'b1;
    repeat (HALF) tick();
    for (int k = 0; k < nfalls; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        tick();
        dead = 1'b1;
        mdl_ctrl = 12'h000;
        mdl_ch = 3'd0;
        exp_miso = 1'b1;
        tick();
        rst = 1'b0;
        tick();
      end
      if (k < 16) word = {word[14:0], spi_bus.spi_miso};
      spi_bus.spi_mosi = (k < 12) ? cw[11 - k] : 1'b0;
      spi_bus.spi_sck = 1'b0;
      miso_chk = dead;
      repeat (LAT) tick();
      if (!dead) exp_miso = (k < 15) ? expw[14 - k] : 1'b0;
      miso_chk = 1'b1;
      repeat (HALF - LAT) tick();
      spi_bus.spi_sck = 1'b1;
      repeat (HALF) tick();
    end
    spi_bus.spi_ss = 1'b1;
    miso_chk = dead;
    repeat (LAT) tick();
    exp_miso = 1'b1;
    miso_chk = 1'b1;
    if (!dead) begin
      if (nfalls >= 16) begin
        exp_frame = 1'b1;
        if (cw[11]) begin
          mdl_ctrl = cw;
          mdl_ch = cw[8:6];
        end
      end else begin
        exp_abort = 1'b1;
      end
    end
    tick();
    exp_frame = 1'b0;
    exp_abort = 1'b0;
    repeat (HALF) tick();
    if (!dead && nfalls >= 16) chk("frame_word", word, expw);
  endtask

  logic [15:0] w;

  initial begin
    rst = 1'b1;
    spi_bus.spi_ss = 1'b1;
    spi_bus.spi_sck = 1'b1;
    spi_bus.spi_mosi = 1'b0;
    for (int i = 0; i < 8; i++) ch_value[i] = 12'(i * 12'h111);
    ch_value[0] = 12'h123;
    ch_value[3] = 12'hABC;
    ch_value[5] = 12'h5A5;
    tick();
    chk_on = 1'b1;
    miso_chk = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Basic write, reset coding is offset binary
    frame(12'h8F3, 16, -1, w);
    chk("basic_word", w, 16'h0923);
    chk("basic_ctrl", 16'(o_ctrl), 16'h08F3);
    chk("basic_ch", 16'(o_ch), 16'h0003);

    // Channel pipeline with straight binary; this frame writes CODING=0
    frame(12'h8F2, 16, -1, w);
    chk("pipe_word", w, 16'h3ABC);

    // No-write frame returns offset-binary data, control unchanged
    frame(12'h0F3, 16, -1, w);
    chk("coding_word", w, 16'h32BC);
    chk("nowrite_ctrl", 16'(o_ctrl), 16'h08F2);

    // Abort after 10 falls, then a normal frame selecting channel 5
    frame(12'h8F3, 10, -1, w);
    chk("abort_ctrl", 16'(o_ctrl), 16'h08F2);
    frame(12'h941, 16, -1, w);
    chk("after_abort_word", w, 16'h32BC);
    chk("after_abort_ch", 16'(o_ch), 16'h0005);

    // Extra falls beyond 16 are ignored
    frame(12'h000, 20, -1, w);
    chk("long_word", w, 16'h55A5);

    // Reset mid-frame at fall 5, then channel 0 offset-binary data
    frame(12'h8F3, 16, 5, w);
    chk("rst_ctrl", 16'(o_ctrl), 16'h0000);
    frame(12'h000, 16, -1, w);
    chk("post_rst_word", w, 16'h0923);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
